serial_add_ctrl: RTL and testbench

- Bit-serial adder/subtractor controller that sequences one `full_add_dataflow` instance over WIDTH-bit operands, one bit per clock, LSB first.
- Holds the ripple carry in a flop between cycles. Trades latency for area: one full-adder cell serves any operand width.
- Sits between a requesting datapath and the shared single-bit adder cell. Uses a start/busy/done handshake.

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/full_add_dataflow.sv | 11 +
 rtl/serial_add_ctrl.sv | 73 +++++++
 tb/tb_serial_add_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and default width for the bit-serial adder controller
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_add_dataflow.sv
// full_add_dataflow: single-bit full adder cell
module full_add_dataflow (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ carry_in;
  assign carry = (a & b) | (carry_in & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: sequences one full-adder cell over WIDTH-bit operands, LSB first
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_d;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0] cnt_q;
  logic c_q, fa_sum, fa_carry, load, last;
  full_add_dataflow u_fa (
    .a(a_q[0]),
    .b(b_q[0]),
    .carry_in(c_q),
    .sum(fa_sum),
    .carry(fa_carry)
  );
  assign load  = start && (state_q == IDLE || state_q == DONE);
  assign last  = state_q == RUN && cnt_q == CW'(WIDTH - 1);
  assign res_d = {fa_sum, res_q};
  assign busy  = state_q == RUN;
  assign done  = state_q == DONE;
  always_comb
    state_d = load ? RUN : last ? DONE : state_q == DONE ? IDLE : state_q;
  // subtract is a + ~b + 1: invert B at load and seed the carry with 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a_q   <= op_a;
        b_q   <= sub ? ~op_b : op_b;
        c_q   <= sub | carry_in;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        c_q   <= fa_carry;
        cnt_q <= cnt_q + 1'b1;
        res_q <= res_d[WIDTH-1:1];
        if (last) begin
          sum_out   <= res_d;
          carry_out <= fa_carry;
          ovf       <= c_q ^ fa_carry;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench with an arithmetic reference model and randomized operations
module tb_serial_add_ctrl;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    int           cyc;
  } exp_t;
  logic clk = 0, rst_n = 0, start = 0, sub = 0, carry_in = 0;
  logic [W-1:0] op_a = '0, op_b = '0, sum_out;
  logic busy, done, carry_out, ovf;
  int checks = 0, passes = 0, cyc = 0;
  exp_t q[$];
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .carry_in(carry_in),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .sum_out(sum_out), .carry_out(carry_out), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic exp_t model(input bit s, input bit [W-1:0] a, input bit [W-1:0] b, input bit c);
    exp_t e;
    int ua = a, ub = b, sa = $signed(a), sb = $signed(b), r, sr;
    if (s) begin
      r = ua - ub;
      sr = sa - sb;
      e.co = ua >= ub;
    end else begin
      r = ua + ub + int'(c);
      sr = sa + sb + int'(c);
      e.co = r >= (1 << W);
    end
    e.sum = r[W-1:0];
    e.ovf = sr > (2 ** (W - 1)) - 1 || sr < -(2 ** (W - 1));
    e.cyc = 0;
    return e;
  endfunction
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = q.pop_front();
        chk("sum_out", sum_out, e.sum);
        chk("carry_out", carry_out, e.co);
        chk("ovf", ovf, e.ovf);
        chk("done_latency", cyc, e.cyc);
        chk("busy_in_done", busy, 0);
      end
    end
  end
  task automatic launch(input bit sync, input bit s, input bit [W-1:0] a, input bit [W-1:0] b, input bit c);
    exp_t e;
    if (sync) @(negedge clk);
    start = 1; sub = s; op_a = a; op_b = b; carry_in = c;
    @(posedge clk);
    #1;
    e = model(s, a, b, c);
    e.cyc = cyc + W;
    q.push_back(e);
    start = 0;
    sub = $urandom_range(0, 1);
    op_a = W'($urandom);
    op_b = W'($urandom);
    carry_in = $urandom_range(0, 1);
  endtask
  task automatic wait_done;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic wait_idle;
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("idle_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    launch(1, 0, 8'h5A, 8'h33, 0); wait_idle();
    launch(1, 0, 8'hFF, 8'h01, 0); wait_idle();
    launch(1, 0, 8'hFF, 8'h01, 1); wait_idle();
    launch(1, 1, 8'h10, 8'h01, 0); wait_idle();
    launch(1, 1, 8'h80, 8'h01, 0); wait_idle();
    launch(1, 0, 8'h21, 8'h42, 0);
    repeat (2) @(negedge clk);
    start = 1; sub = 1; op_a = 8'hC3; op_b = 8'h7E;
    @(posedge clk);
    #1;
    start = 0;
    chk("busy_ignored_start", busy, 1);
    wait_idle();
    launch(1, 0, 8'h12, 8'h34, 0);
    repeat (4) @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_out, 0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    launch(1, 0, 8'h12, 8'h34, 1); wait_idle();
    launch(1, 0, 8'h02, 8'h03, 0);
    wait_done();
    launch(0, 0, 8'h01, 8'h01, 0);
    chk("b2b_busy", busy, 1);
    wait_idle();
    for (int i = 0; i < 24; i++) begin
      launch(1, $urandom_range(0, 1), W'($urandom), W'($urandom), $urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        wait_done();
        launch(0, $urandom_range(0, 1), W'($urandom), W'($urandom), $urandom_range(0, 1));
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
